// File: rtl/axis_noc_packetizer.sv
// AXI-stream to NoC packetizer: buffers multi-beat packets and serialises them
// into a head flit plus 32-bit body flits under credit-based flow control.
module axis_noc_packetizer #(
    parameter int DEST_WIDTH = 4,
    parameter int AXIW       = 64,
    parameter int DEPTH      = 8,
    parameter int CREDITS    = 4,
    parameter int MAX_BODY   = 16,
    parameter int FLIT_W     = 36
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [AXIW-1:0]                s_axis_tdata,
    input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
    input  logic                           s_axis_tlast,
    output logic [FLIT_W-1:0]              flit_out,
    input  logic                           credit_in,
    output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
    output logic                           err_credit_ovf,
    output logic                           busy
);

    localparam int NPB  = AXIW / 32;
    localparam int SW   = (NPB > 1) ? $clog2(NPB) : 1;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(CREDITS + 1);
    localparam int BW   = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
    localparam int FW   = AXIW + DEST_WIDTH + 1;

    localparam logic [SW-1:0] LAST_SLICE = SW'(NPB - 1);
    localparam logic [BW-1:0] LAST_BODY  = BW'(MAX_BODY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    logic [FW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CNTW-1:0]        r_count;
    logic [CNTW-1:0]        w_count_next;
    logic                   r_tready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;

    logic [FW-1:0]          w_head_entry;
    logic [AXIW-1:0]        w_head_data;
    logic [DEST_WIDTH-1:0]  w_head_dest;
    logic                   w_head_last;
    logic [NPB-1:0][31:0]   w_slices;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DEST_WIDTH-1:0]  r_dest;
    logic [DEST_WIDTH-1:0]  w_dest_next;
    logic [BW-1:0]          r_body_cnt;
    logic [BW-1:0]          w_body_next;
    logic [SW-1:0]          r_slice_idx;
    logic [SW-1:0]          w_slice_next;
    logic [FLIT_W-1:0]      r_flit;
    logic [FLIT_W-1:0]      w_flit_next;
    logic                   w_issue;
    logic                   w_has_credit;
    logic                   w_last_slice;
    logic                   w_pkt_end;
    logic                   w_tail;
    logic [31:0]            w_dest_ext;

    logic [CW-1:0]          r_credit_cnt;
    logic                   r_err;
    logic                   r_busy;

    assign w_push       = s_axis_tvalid & r_tready;
    assign w_empty      = (r_count == {CNTW{1'b0}});
    assign w_head_entry = r_mem[r_rd_ptr];
    assign w_head_last  = w_head_entry[0];
    assign w_head_dest  = w_head_entry[DEST_WIDTH:1];
    assign w_head_data  = w_head_entry[FW-1 -: AXIW];
    assign w_slices     = w_head_data;
    assign w_dest_ext   = {{(32-DEST_WIDTH){1'b0}}, r_dest};

    assign w_has_credit = (r_credit_cnt != {CW{1'b0}});
    assign w_last_slice = (r_slice_idx == LAST_SLICE);
    assign w_pkt_end    = w_last_slice & w_head_last;
    assign w_tail       = w_pkt_end | (r_body_cnt == LAST_BODY);

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNTW'(1);
            2'b01:   w_count_next = r_count - CNTW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Beat storage; no reset needed since occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_axis_tdata, s_axis_tdest, s_axis_tlast};
        end
    end

    // FIFO pointers, count and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CNTW{1'b0}};
            r_tready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count  <= w_count_next;
            r_tready <= (w_count_next != CNTW'(DEPTH));
        end
    end

    // Packetizer next-state, flit assembly and FIFO pop
    always_comb begin
        w_state_next = r_state;
        w_dest_next  = r_dest;
        w_body_next  = r_body_cnt;
        w_slice_next = r_slice_idx;
        w_flit_next  = {FLIT_W{1'b0}};
        w_issue      = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = S_HEAD;
                    w_dest_next  = w_head_dest;
                    w_slice_next = {SW{1'b0}};
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_HEAD: begin
                // slice_idx is kept so a forced split resumes mid-beat
                if (w_has_credit) begin
                    w_issue      = 1'b1;
                    w_flit_next  = {1'b1, 1'b1, 1'b0, 1'b0, w_dest_ext};
                    w_body_next  = {BW{1'b0}};
                    w_state_next = S_BODY;
                end else begin
                    w_state_next = S_HEAD;
                end
            end
            S_BODY: begin
                if (w_has_credit && !w_empty) begin
                    w_issue     = 1'b1;
                    w_flit_next = {1'b1, 1'b0, w_tail, 1'b0, w_slices[r_slice_idx]};
                    w_body_next = r_body_cnt + BW'(1);
                    if (w_last_slice) begin
                        w_pop        = 1'b1;
                        w_slice_next = {SW{1'b0}};
                    end else begin
                        w_slice_next = r_slice_idx + SW'(1);
                    end
                    if (w_pkt_end) begin
                        w_state_next = S_IDLE;
                    end else if (w_tail) begin
                        w_state_next = S_HEAD;
                    end else begin
                        w_state_next = S_BODY;
                    end
                end else begin
                    w_state_next = S_BODY;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Packetizer state and registered flit output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dest      <= {DEST_WIDTH{1'b0}};
            r_body_cnt  <= {BW{1'b0}};
            r_slice_idx <= {SW{1'b0}};
            r_flit      <= {FLIT_W{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dest      <= w_dest_next;
            r_body_cnt  <= w_body_next;
            r_slice_idx <= w_slice_next;
            r_flit      <= w_flit_next;
            r_busy      <= (w_state_next != S_IDLE) || (w_count_next != {CNTW{1'b0}});
        end
    end

    // Credit counter with saturation and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit_cnt <= CW'(CREDITS);
            r_err        <= 1'b0;
        end else begin
            case ({w_issue, credit_in})
                2'b10: r_credit_cnt <= r_credit_cnt - CW'(1);
                2'b01: begin
                    if (r_credit_cnt == CW'(CREDITS)) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credit_cnt <= r_credit_cnt + CW'(1);
                    end
                end
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

    assign s_axis_tready  = r_tready;
    assign flit_out       = r_flit;
    assign credit_cnt     = r_credit_cnt;
    assign err_credit_ovf = r_err;
    assign busy           = r_busy;

endmodule
